// File: rtl/tetris_pkg.sv
// Shared board defaults, FSM state encoding and small helpers for the row-clear engine.
package tetris_pkg;

    localparam int unsigned BoardWDefault = 10;
    localparam int unsigned BoardHDefault = 24;
    localparam int unsigned CellW = 6;
    localparam int unsigned AddrW = 8;
    localparam logic [CellW-1:0] EmptyColourDefault = 6'b000000;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StCopy,
        StFill,
        StDone
    } state_e;

    // Signed so a row index can step one below zero when the scan wraps.
    typedef logic signed [7:0] row_t;

    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v >= 3'd4) ? 3'd4 : v + 3'd1;
    endfunction

    // Where the pass goes once row 0 has been dealt with.
    function automatic state_e after_last_row(input row_t dst);
        return (dst < 0) ? StDone : StFill;
    endfunction

endpackage

// File: rtl/clear_rows_if.sv
// Control and board-RAM bus of the row-clear engine; master is the engine, slave the environment.
interface clear_rows_if;

    logic                             start;
    logic [tetris_pkg::CellW-1:0]     ram_Q;
    logic [tetris_pkg::AddrW-1:0]     ram_addr;
    logic [tetris_pkg::CellW-1:0]     ram_data;
    logic                             ram_wren;
    logic                             busy;
    logic                             done;
    logic [2:0]                       rows_cleared;

    modport master (
        input  start, ram_Q,
        output ram_addr, ram_data, ram_wren, busy, done, rows_cleared
    );

    modport slave (
        output start, ram_Q,
        input  ram_addr, ram_data, ram_wren, busy, done, rows_cleared
    );

endinterface

// File: rtl/coord_to_addr.sv
// Linear board-RAM address from a cell coordinate: y * BOARD_W + x.
module coord_to_addr #(
    parameter int unsigned BOARD_W = 10
) (
    input  logic [4:0] x,
    input  logic [4:0] y,
    output logic [7:0] addr
);

    assign addr = 8'((32'(y) * BOARD_W) + 32'(x));

endmodule

// File: rtl/clear_rows.sv
// Removes full rows from the board RAM and compacts the rest downward, one RAM access per cycle.
// Optional CLEAR_ROWS_TOTAL_EN adds a saturating lines_total accumulator output.
module clear_rows
    import tetris_pkg::*;
#(
    parameter int unsigned      BOARD_W      = BoardWDefault,
    parameter int unsigned      BOARD_H      = BoardHDefault,
    parameter logic [CellW-1:0] EMPTY_COLOUR = EmptyColourDefault
) (
    input logic          clk,
    input logic          resetn,
    clear_rows_if.master bus
`ifdef CLEAR_ROWS_TOTAL_EN
    ,
    output logic [9:0]   lines_total
`endif
);

    localparam logic [4:0] ChkLast  = 5'(BOARD_W);
    localparam logic [4:0] CopyLast = 5'(2 * BOARD_W - 1);
    localparam logic [4:0] FillLast = 5'(BOARD_W - 1);
    localparam row_t       TopRow   = row_t'(BOARD_H - 1);

    state_e           state_q, state_d;
    logic [4:0]       x_q, x_d;
    row_t             src_q, src_d, dst_q, dst_d;
    logic [2:0]       cnt_q, cnt_d, rows_cleared_q;
    logic             full_q, full_d;
    logic             cell_full, row_full;
    logic [4:0]       col, row;
    logic [7:0]       addr;
    logic [CellW-1:0] wdata;
    logic             wren;

    assign cell_full = (bus.ram_Q != EMPTY_COLOUR);
    assign row_full  = full_q & cell_full;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= StIdle;
            x_q            <= '0;
            src_q          <= '0;
            dst_q          <= '0;
            cnt_q          <= '0;
            full_q         <= 1'b1;
            rows_cleared_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            if (state_q == StDone) rows_cleared_q <= cnt_q;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        full_d  = full_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    src_d   = TopRow;
                    dst_d   = TopRow;
                    cnt_d   = '0;
                    x_d     = '0;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                // Read data lags the address by one cycle, so cell x is judged at phase x+1.
                x_d    = x_q + 5'd1;
                full_d = (x_q == 5'd0) ? 1'b1 : row_full;
                if (x_q == ChkLast) begin
                    x_d = '0;
                    if (row_full) begin
                        cnt_d = sat_inc(cnt_q);
                        src_d = src_q - 8'sd1;
                        if (src_q == 8'sd0) state_d = after_last_row(dst_q);
                    end else if (src_q == dst_q) begin
                        src_d = src_q - 8'sd1;
                        dst_d = dst_q - 8'sd1;
                        if (src_q == 8'sd0) state_d = after_last_row(dst_q - 8'sd1);
                    end else begin
                        state_d = StCopy;
                    end
                end
            end
            StCopy: begin
                x_d = x_q + 5'd1;
                if (x_q == CopyLast) begin
                    x_d     = '0;
                    src_d   = src_q - 8'sd1;
                    dst_d   = dst_q - 8'sd1;
                    state_d = (src_q == 8'sd0) ? after_last_row(dst_q - 8'sd1) : StCheck;
                end
            end
            StFill: begin
                x_d = x_q + 5'd1;
                if (x_q == FillLast) begin
                    x_d   = '0;
                    dst_d = dst_q - 8'sd1;
                    if (dst_q == 8'sd0) state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Even COPY phases read the source cell, odd phases write it to the destination.
    always_comb begin
        col   = '0;
        row   = '0;
        wren  = 1'b0;
        wdata = EMPTY_COLOUR;
        case (state_q)
            StCheck: begin
                col = x_q;
                row = 5'(src_q);
            end
            StCopy: begin
                col = {1'b0, x_q[4:1]};
                row = x_q[0] ? 5'(dst_q) : 5'(src_q);
                if (x_q[0]) begin
                    wren  = 1'b1;
                    wdata = bus.ram_Q;
                end
            end
            StFill: begin
                col  = x_q;
                row  = 5'(dst_q);
                wren = 1'b1;
            end
            default: ;
        endcase
    end

    coord_to_addr #(
        .BOARD_W(BOARD_W)
    ) u_coord_to_addr (
        .x   (col),
        .y   (row),
        .addr(addr)
    );

    assign bus.ram_addr     = addr;
    assign bus.ram_data     = wdata;
    assign bus.ram_wren     = wren;
    assign bus.busy         = (state_q != StIdle);
    assign bus.done         = (state_q == StDone);
    assign bus.rows_cleared = rows_cleared_q;

`ifdef CLEAR_ROWS_TOTAL_EN
    logic [10:0] total_sum;

    assign total_sum = {1'b0, lines_total} + 11'(cnt_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lines_total <= '0;
        end else if (state_q == StDone) begin
            lines_total <= (total_sum > 11'd999) ? 10'd999 : total_sum[9:0];
        end
    end
`endif

endmodule

// File: tb/tb_clear_rows.sv
// Bench for clear_rows: behavioural board RAM, software row-clear model and a pass scoreboard.
module tb_clear_rows;

    localparam int W = 10;
    localparam int H = 24;
    localparam logic [5:0] E = 6'b000000;

    typedef struct {
        int rc;
        int lat;
        int wr;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic       load_en;
    logic [5:0] ram_q_r;
    logic [5:0] mem  [0:255];
    logic [5:0] img  [0:255];
    logic [5:0] expm [0:255];
    int         wr_cnt = 0;
    int         total = 0;
    int         bad = 0;
    exp_t       sb[$];

    always #5 clk = ~clk;

    clear_rows_if bus ();

`ifdef CLEAR_ROWS_TOTAL_EN
    logic [9:0] lines_total;
`endif

    clear_rows dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
`ifdef CLEAR_ROWS_TOTAL_EN
        ,
        .lines_total(lines_total)
`endif
    );

    assign bus.ram_Q = ram_q_r;

    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < 256; i++) mem[i] <= img[i];
        end else if (bus.ram_wren) begin
            mem[bus.ram_addr] <= bus.ram_data;
        end
        ram_q_r <= mem[bus.ram_addr];
        if (bus.ram_wren) wr_cnt <= wr_cnt + 1;
    end

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = E;
    endtask

    task automatic row_full(input int r);
        for (int x = 0; x < W; x++) img[r*W+x] = 6'(1 + ((r * 7 + x * 3) % 63));
    endtask

    task automatic row_part(input int r);
        for (int x = 0; x < W; x++) img[r*W+x] = 6'(1 + ((r * 5 + x * 11) % 63));
        img[r*W+(r%W)] = E;
    endtask

    task automatic row_rand(input int r);
        for (int x = 0; x < W; x++) img[r*W+x] = 6'($urandom_range(1, 63));
        img[r*W+int'($urandom_range(0, W - 1))] = E;
    endtask

    task automatic load_board();
        @(negedge clk);
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Plain software compaction of img into expm; pushes what the pass must produce.
    task automatic model_push();
        exp_t e;
        int   d, cnt, copies;
        bit   full;
        d = H - 1;
        cnt = 0;
        copies = 0;
        for (int s = H - 1; s >= 0; s--) begin
            full = 1'b1;
            for (int x = 0; x < W; x++) if (img[s*W+x] == E) full = 1'b0;
            if (full) begin
                cnt++;
            end else begin
                if (s != d) copies++;
                for (int x = 0; x < W; x++) expm[d*W+x] = img[s*W+x];
                d--;
            end
        end
        for (int r = d; r >= 0; r--) for (int x = 0; x < W; x++) expm[r*W+x] = E;
        e.rc  = (cnt > 4) ? 4 : cnt;
        e.wr  = 10 * copies + 10 * (d + 1);
        e.lat = 11 * H + 20 * copies + 10 * (d + 1) + 1;
        sb.push_back(e);
    endtask

    task automatic run_pass(input string name, input bit poke_busy);
        exp_t        e;
        int          n, w0;
        logic [59:0] g, x_exp;
        model_push();
        load_board();
        w0 = wr_cnt;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        while (bus.done !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
            bus.start = poke_busy && (n == 40);
        end
        bus.start = 1'b0;
        e = sb.pop_front();
        total++;
        if (n != e.lat) begin
            bad++;
            $display("FAIL %s done_cycle got %0d want %0d", name, n, e.lat);
        end
        @(negedge clk);
        total++;
        if (bus.rows_cleared !== 3'(e.rc)) begin
            bad++;
            $display("FAIL %s rows_cleared got %0d want %0d", name, bus.rows_cleared, e.rc);
        end
        total++;
        if (wr_cnt - w0 != e.wr) begin
            bad++;
            $display("FAIL %s write_count got %0d want %0d", name, wr_cnt - w0, e.wr);
        end
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL %s idle_after got busy=%b done=%b want 0 0", name, bus.busy, bus.done);
        end
        for (int r = 0; r < H; r++) begin
            for (int x = 0; x < W; x++) begin
                g[x*6+:6]     = mem[r*W+x];
                x_exp[x*6+:6] = expm[r*W+x];
            end
            total++;
            if (g !== x_exp) begin
                bad++;
                $display("FAIL %s row%0d got %h want %h", name, r, g, x_exp);
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #1;
        total++;
        if ({bus.ram_wren, bus.busy, bus.done} !== 3'b000) begin
            bad++;
            $display("FAIL reset_ctrl got %b want 000", {bus.ram_wren, bus.busy, bus.done});
        end
        total++;
        if (bus.rows_cleared !== 3'd0) begin
            bad++;
            $display("FAIL reset_rows_cleared got %0d want 0", bus.rows_cleared);
        end
        total++;
        if (bus.ram_addr !== 8'd0 || bus.ram_data !== E) begin
            bad++;
            $display("FAIL reset_bus got addr=%0d data=%0d want 0 0", bus.ram_addr, bus.ram_data);
        end
`ifdef CLEAR_ROWS_TOTAL_EN
        total++;
        if (lines_total !== 10'd0) begin
            bad++;
            $display("FAIL reset_lines_total got %0d want 0", lines_total);
        end
`endif
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_no_full();
        for (int r = 0; r < H; r++) row_rand(r);
        run_pass("no_full", 1'b0);
    endtask

    task automatic test_one_row();
        clear_img();
        row_full(23);
        for (int r = 20; r <= 22; r++) row_part(r);
        run_pass("one_row", 1'b0);
    endtask

    task automatic test_four_rows();
        clear_img();
        for (int r = 20; r <= 23; r++) row_full(r);
        run_pass("four_rows", 1'b0);
    endtask

    task automatic test_interleaved();
        clear_img();
        row_full(23);
        row_part(22);
        row_full(21);
        row_part(20);
        run_pass("interleaved", 1'b0);
    endtask

    task automatic test_start_while_busy();
        for (int r = 0; r < H; r++) row_rand(r);
        row_full(5);
        run_pass("start_busy", 1'b1);
    endtask

    task automatic test_reset_mid();
        int n;
        clear_img();
        row_full(23);
        row_part(22);
        row_full(21);
        row_part(20);
        load_board();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.ram_wren !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 400) begin
            bad++;
            $display("FAIL reset_mid copy_write got none want write within 400 cycles");
        end
        resetn = 1'b0;
        #1;
        total++;
        if ({bus.ram_wren, bus.busy, bus.done} !== 3'b000) begin
            bad++;
            $display("FAIL reset_mid ctrl got %b want 000", {bus.ram_wren, bus.busy, bus.done});
        end
        @(negedge clk);
        resetn = 1'b1;
        test_one_row();
    endtask

`ifdef CLEAR_ROWS_TOTAL_EN
    task automatic test_total();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        total++;
        if (lines_total !== 10'd0) begin
            bad++;
            $display("FAIL total_reset got %0d want 0", lines_total);
        end
        test_one_row();
        test_four_rows();
        clear_img();
        row_full(23);
        row_part(22);
        row_full(21);
        row_part(20);
        run_pass("total_interleaved", 1'b1);
        total++;
        if (lines_total !== 10'd7) begin
            bad++;
            $display("FAIL lines_total got %0d want 7", lines_total);
        end
    endtask
`endif

    initial begin
        bus.start = 1'b0;
        load_en   = 1'b0;
        test_reset();
        test_no_full();
        test_one_row();
        test_four_rows();
        test_interleaved();
        test_start_while_busy();
        test_reset_mid();
`ifdef CLEAR_ROWS_TOTAL_EN
        test_total();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clear_rows.md
CLEAR_ROWS -- requirements
Module: clear_rows

Interface
REQ-001 SHALL have parameter BOARD_W, default 10, board width in cells.
REQ-002 SHALL have parameter BOARD_H, default 24, board height in rows, including 4 hidden top rows.
REQ-003 SHALL have parameter EMPTY_COLOUR, default 6'b000000, cell value meaning "no block".
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on posedge.
REQ-005 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: request a row-clear pass; sampled only in IDLE.
REQ-007 SHALL have port ram_Q, input, 6 bits: board RAM read data, valid 1 cycle after ram_addr is presented.
REQ-008 SHALL have port ram_addr, output, 8 bits: board RAM address, computed as y*BOARD_W + x.
REQ-009 SHALL have port ram_data, output, 6 bits: board RAM write data.
REQ-010 SHALL have port ram_wren, output, 1 bit: board RAM write enable.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port done, output, 1 bit: single-cycle pulse when a pass completes.
REQ-013 SHALL have port rows_cleared, output, 3 bits: full rows removed by the last pass, range 0..4; held until the next pass completes.

Function
REQ-014 SHALL implement the FSM states IDLE, CHECK, COPY, FILL and DONE.
REQ-015 SHALL perform one RAM access per cycle, since the RAM is single-port.
REQ-016 SHALL, on start in IDLE, set src_row = dst_row = BOARD_H-1, clear the internal count, and enter CHECK on the next cycle.
REQ-017 SHALL, in CHECK, read cells x=0..9 of src_row on cycles 0..9 and resolve the full flag on cycle 10, so each row takes 11 cycles.
REQ-018 SHALL treat a row as full when every cell != EMPTY_COLOUR.
REQ-019 SHALL, when the row is full, increment the count, decrement src_row, and stay in CHECK without writing.
REQ-020 SHALL, when the row is not full and src_row == dst_row, decrement both rows and perform no writes.
REQ-021 SHALL, when the row is not full and src_row != dst_row, enter COPY.
REQ-022 SHALL, in COPY, alternately read (src_row, x) and write that cell's ram_Q to (dst_row, x) for x=0..9, taking 20 cycles, then decrement both rows and return to CHECK.
REQ-023 SHALL, after row 0 has been checked (src_row wraps below 0), enter FILL if dst_row >= 0, otherwise enter DONE.
REQ-024 SHALL, in FILL, write EMPTY_COLOUR to every cell of rows dst_row..0, at one write per cycle.
REQ-025 SHALL, in DONE, latch rows_cleared and pulse done for exactly 1 cycle, then return to IDLE.
REQ-026 SHALL keep ram_wren high only on COPY write cycles and FILL cycles.
REQ-027 SHALL hold ram_data = EMPTY_COLOUR and ram_addr = 0 in IDLE.
REQ-028 SHALL ignore start while busy.
REQ-029 SHALL, with no full rows, issue zero writes and assert done exactly 265 cycles after the start cycle.
REQ-030 SHALL saturate the internal count at 4.

Reset
REQ-031 SHALL, while resetn is low, force state IDLE, ram_wren=0, busy=0, done=0, rows_cleared=0, ram_addr=0 and ram_data=EMPTY_COLOUR, regardless of clk.
REQ-032 SHALL, on reset mid-pass, abandon the pass with no further writes; a partially compacted board is acceptable.

Configuration
REQ-033 SHALL use the macro CLEAR_ROWS_TOTAL_EN.
REQ-034 SHALL, when CLEAR_ROWS_TOTAL_EN is defined, add output lines_total (10 bits), which accumulates rows_cleared at each DONE, saturates at 999, and is cleared only by resetn.
REQ-035 SHALL, when CLEAR_ROWS_TOTAL_EN is undefined, omit the lines_total port and its logic entirely.

Structure
REQ-036 SHALL place BOARD_W, BOARD_H, EMPTY_COLOUR defaults and the FSM state encoding in shared package tetris_pkg.
REQ-037 SHALL generate ram_addr with one instance of the existing coord_to_addr sub-module, fed by a muxed (x, y) selected from src_row or dst_row by state and phase.

Verification
REQ-038 SHALL cover: board with no full rows, then start -> zero ram_wren cycles, done at cycle 265, rows_cleared=0.
REQ-039 SHALL cover: only row 23 full, rows 20..22 patterned -> rows 21..23 hold the former 20..22, row 0 empty, rows_cleared=1.
REQ-040 SHALL cover: rows 20..23 full, the rest empty -> whole board equals EMPTY_COLOUR, rows_cleared=4.
REQ-041 SHALL cover: full rows 23 and 21, interleaved with non-full rows 22 and 20 -> row 23 = old 22, row 22 = old 20, rows 0..1 empty, rows_cleared=2.
REQ-042 SHALL cover: resetn low during COPY -> ram_wren falls immediately, busy=0, and a later start runs a normal pass.
REQ-043 SHALL cover: with CLEAR_ROWS_TOTAL_EN defined, three passes clearing 1, 4 and 2 rows -> lines_total=7; start pulsed while busy -> no effect.
